// File: rtl/sensor_cmd_scheduler.sv
// sensor_cmd_scheduler: validates a host (address, command) pair, runs one
// DHT11 measurement, and returns a 2-byte response through the UART TX.
// Optional feature macro: CONTINUOUS_EN (periodic monitoring session).
//
// state         | meaning
// --------------+----------------------------------------------------
// S_IDLE        | waiting for a command edge or a continuous tick
// S_CHECK       | validate latched address/code, update session
// S_START       | pulse sensor_start, clear timeout counter
// S_WAIT_SENSOR | wait for done / error / timeout
// S_LOAD        | build response pair, load byte 0
// S_SEND0       | pulse tx_start for byte 0 once TX is free
// S_WAIT0       | wait for byte 0 to finish (busy high then low)
// S_SEND1       | pulse tx_start for byte 1 once TX is free
// S_WAIT1       | wait for byte 1 to finish
module sensor_cmd_scheduler #(
  parameter int NUM_SENSORS    = 32,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int PERIOD_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_address,
  input  logic [7:0]  cmd_code,
  output logic [7:0]  sensor_addr,
  output logic        sensor_start,
  input  logic        sensor_done,
  input  logic        sensor_error,
  input  logic [39:0] sensor_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        cmd_drop
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_START, S_WAIT_SENSOR, S_LOAD,
    S_SEND0, S_WAIT0, S_SEND1, S_WAIT1
  } state_t;

  localparam logic [7:0] CODE_STATUS = 8'h00;
  localparam logic [7:0] CODE_TEMP   = 8'h01;
  localparam logic [7:0] CODE_HUM    = 8'h02;
`ifdef CONTINUOUS_EN
  localparam logic [7:0] CODE_CTEMP  = 8'h03;
  localparam logic [7:0] CODE_CHUM   = 8'h04;
  localparam logic [7:0] CODE_STOP_T = 8'h05;
  localparam logic [7:0] CODE_STOP_H = 8'h06;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] NUM_S = 9'(NUM_SENSORS);

  state_t        state, state_nxt;
  logic          cmd_valid_q;
  logic          cmd_edge;
  logic [7:0]    addr_q, code_q;
  logic          addr_bad;
  logic          res_fault_q;
  logic [7:0]    hum_q, temp_q;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          seen_busy_q;
  logic [7:0]    resp_code, resp_val;
  logic          tick;
  logic [7:0]    tick_addr, tick_code;
  logic          unused_data;

  assign cmd_edge    = cmd_valid & ~cmd_valid_q;
  assign addr_bad    = {1'b0, addr_q} >= NUM_S;
  assign to_hit      = (to_cnt == TO_LAST);
  assign unused_data = ^{sensor_data[31:24], sensor_data[15:0]};

`ifdef CONTINUOUS_EN
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);

  logic          sess_active_q, sess_hum_q, tick_pend_q;
  logic [7:0]    sess_addr_q;
  logic [PW-1:0] per_cnt;

  assign tick      = (state == S_IDLE) && sess_active_q &&
                     ((per_cnt == PER_LAST) || tick_pend_q);
  assign tick_addr = sess_addr_q;
  assign tick_code = sess_hum_q ? CODE_HUM : CODE_TEMP;

  // Session register and period counter; a tick lost to a command edge is held pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sess_active_q <= 1'b0;
      sess_hum_q    <= 1'b0;
      sess_addr_q   <= '0;
      tick_pend_q   <= 1'b0;
      per_cnt       <= '0;
    end else begin
      if (state == S_IDLE && sess_active_q)
        per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
      if (tick)
        tick_pend_q <= cmd_edge;
      if (state == S_CHECK && !addr_bad) begin
        case (code_q)
          CODE_CTEMP, CODE_CHUM: begin
            sess_active_q <= 1'b1;
            sess_hum_q    <= (code_q == CODE_CHUM);
            sess_addr_q   <= addr_q;
            per_cnt       <= '0;
            tick_pend_q   <= 1'b0;
          end
          CODE_STOP_T: if (!sess_hum_q) begin
            sess_active_q <= 1'b0;
            tick_pend_q   <= 1'b0;
          end
          CODE_STOP_H: if (sess_hum_q) begin
            sess_active_q <= 1'b0;
            tick_pend_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
`else
  assign tick      = 1'b0;
  assign tick_addr = 8'h00;
  assign tick_code = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and pulse outputs.
  always_comb begin
    state_nxt    = state;
    sensor_start = 1'b0;
    tx_start     = 1'b0;
    busy         = (state != S_IDLE);
    cmd_drop     = cmd_edge && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (cmd_edge)  state_nxt = S_CHECK;
        else if (tick) state_nxt = S_START;
      end
      S_CHECK: begin
        state_nxt = S_LOAD;
        if (!addr_bad) begin
          case (code_q)
            CODE_STATUS, CODE_TEMP, CODE_HUM: state_nxt = S_START;
`ifdef CONTINUOUS_EN
            CODE_CTEMP, CODE_CHUM:            state_nxt = S_START;
`endif
            default:                          state_nxt = S_LOAD;
          endcase
        end
      end
      S_START: begin
        sensor_start = 1'b1;
        state_nxt    = S_WAIT_SENSOR;
      end
      S_WAIT_SENSOR: begin
        if (sensor_error || sensor_done || to_hit) state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_SEND0;
      S_SEND0: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = S_WAIT0;
        end
      end
      S_WAIT0: if (seen_busy_q && !tx_busy) state_nxt = S_SEND1;
      S_SEND1: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = S_WAIT1;
        end
      end
      S_WAIT1: if (seen_busy_q && !tx_busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response pair from the latched request and measurement result.
  always_comb begin
    resp_code = 8'hFF;
    resp_val  = 8'h00;
    if (addr_bad) begin
      resp_code = 8'hFE;
    end else begin
      case (code_q)
        CODE_STATUS: resp_code = res_fault_q ? 8'h1F : 8'h07;
`ifdef CONTINUOUS_EN
        CODE_TEMP, CODE_CTEMP: begin
`else
        CODE_TEMP: begin
`endif
          resp_code = res_fault_q ? 8'h1F : 8'h0A;
          resp_val  = res_fault_q ? 8'h00 : temp_q;
        end
`ifdef CONTINUOUS_EN
        CODE_HUM, CODE_CHUM: begin
`else
        CODE_HUM: begin
`endif
          resp_code = res_fault_q ? 8'h1F : 8'h09;
          resp_val  = res_fault_q ? 8'h00 : hum_q;
        end
`ifdef CONTINUOUS_EN
        CODE_STOP_T: resp_code = 8'h0B;
        CODE_STOP_H: resp_code = 8'h0C;
`endif
        default: resp_code = 8'hFF;
      endcase
    end
  end

  // Datapath: request latch, sensor address, timeout, result capture, TX byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      addr_q      <= '0;
      code_q      <= '0;
      sensor_addr <= '0;
      to_cnt      <= '0;
      res_fault_q <= 1'b0;
      hum_q       <= '0;
      temp_q      <= '0;
      tx_data     <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid;
      case (state)
        S_IDLE: begin
          if (cmd_edge) begin
            addr_q <= cmd_address;
            code_q <= cmd_code;
          end else if (tick) begin
            addr_q      <= tick_addr;
            code_q      <= tick_code;
            sensor_addr <= tick_addr;
          end
        end
        S_CHECK: if (state_nxt == S_START) sensor_addr <= addr_q;
        S_START: to_cnt <= '0;
        S_WAIT_SENSOR: begin
          to_cnt <= to_cnt + 1'b1;
          if (state_nxt == S_LOAD) begin
            // error outranks done; timeout without done is a fault
            res_fault_q <= sensor_error || !sensor_done;
            hum_q       <= sensor_data[39:32];
            temp_q      <= sensor_data[23:16];
          end
        end
        S_LOAD: tx_data <= resp_code;
        S_SEND0, S_SEND1: seen_busy_q <= 1'b0;
        S_WAIT0: begin
          if (tx_busy) seen_busy_q <= 1'b1;
          if (state_nxt == S_SEND1) tx_data <= resp_val;
        end
        S_WAIT1: if (tx_busy) seen_busy_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
